sb_rx_deser: RTL
================

Name: sb_rx_deser

Overview:
Sideband RX deserializer that sits directly upstream of the sideband RDI decoder. It shifts in the serial sideband lane (one bit per i_clk while the lane is valid) and assembles 64-bit packets. It presents each packet to the decoder through a done/sampled handshake, with a one-deep pending buffer. It also enforces the minimum inter-packet idle gap and flags framing errors and overflows.

Parameters:
PKT_W, 64, packet width in bits; must equal the decoder data width.
GAP_UI, 32, minimum consecutive idle (i_ser_valid=0) cycles required between packets.

Ports:
i_clk  in  1  sideband clock
i_rst_n  in  1  asynchronous active-low reset
i_ser_data  in  1  serial sideband data bit, sampled on the rising edge of i_clk
i_ser_valid  in  1  high while a packet is being transmitted on the lane
i_deser_done_sampled  in  1  decoder has captured o_deser_data (level; acted on while o_deser_done=1)
o_deser_data  out  PKT_W  assembled packet; bit k = k-th received bit (LSB first)
o_deser_done  out  1  packet valid; held until sampled
o_overflow  out  1  one-cycle pulse: a completed packet was dropped
o_frame_err  out  1  one-cycle pulse: gap violation or truncated packet
o_parity_err  out  1  one-cycle pulse: parity fail (optional feature; otherwise constant 0)

Behaviour:
- Reset (async, active-low): state=IDLE; bit counter=0; shift register=0; pending empty; o_deser_data=0; all other outputs 0.
- FSM states:
  - IDLE: gap satisfied. On i_ser_valid=1, capture the bit and go to SHIFT with count=1.
  - SHIFT: each cycle with i_ser_valid=1, shift in the bit (written to position count) and increment count.
    - On the PKT_W-th bit: the packet is complete; go to GAP with idle count=0.
    - If i_ser_valid=0 before the packet is complete: discard the partial packet, pulse o_frame_err next cycle, go to GAP with idle count=1.
  - GAP: each cycle with i_ser_valid=0, increment the idle count; at GAP_UI go to IDLE.
    - If i_ser_valid=1 while idle count < GAP_UI: pulse o_frame_err, ignore that bit, reset idle count to 0, stay in GAP.
- Packet completion (the cycle the last bit is captured):
  - If o_deser_done=0 and pending is empty: the next cycle sets o_deser_data to the packet and o_deser_done=1 (latency 1 cycle after the last bit).
  - Else if pending is empty: store the packet in pending.
  - Else: drop the packet; pulse o_overflow next cycle.
- Handshake:
  - While o_deser_done=1, o_deser_data is stable.
  - When i_deser_done_sampled=1 is seen with o_deser_done=1, o_deser_done goes 0 the next cycle.
  - If pending is full, the following cycle loads pending into o_deser_data with o_deser_done=1. This guarantees a low cycle between packets.
  - i_deser_done_sampled while o_deser_done=0 is ignored.
- Simultaneous events:
  - Release and completion in the same cycle, with pending empty: the new packet goes to pending and is presented after the mandatory low cycle.
  - Completion and pending-load in the same cycle: the pending-load happens and the new packet takes the freed pending slot; no overflow.
- Counters: the bit counter is 7 bits and the gap counter is 6 bits, both saturating. A mid-operation async reset discards all packets, including pending.

Optional Feature:
SB_RX_PARITY_CHK_EN
- Defined: on completion, check control parity. Bit 62 (cp) must equal the XOR of bits [61:32] and [31:0], i.e. even parity over [62:0].
  - On mismatch: the packet is discarded (neither presented nor buffered) and o_parity_err pulses for 1 cycle in the cycle after completion.
  - A parity-failed packet never causes o_overflow.
- Not defined: no check is performed, every packet is forwarded, and o_parity_err is tied to 0.

Test Plan:
1. Reset, then 64 valid bits of 0xCAFEBABE_DEADBEEF (LSB first); decoder asserts sampled 2 cycles after done -> o_deser_done=1 one cycle after bit 64 with data 0xCAFEBABE_DEADBEEF, low one cycle after sampled.
2. Three back-to-back packets, each separated by 32 idle cycles, with sampled held 0 -> packet 1 on the output, packet 2 in pending, o_overflow pulse after packet 3. On releasing sampled, done goes 0 for 1 cycle, then packet 2 is presented.
3. i_ser_valid drops after 40 bits -> o_frame_err single pulse, no o_deser_done; a following full packet after 32 idle cycles is delivered correctly.
4. Packet, then i_ser_valid=1 after only 10 idle cycles -> o_frame_err pulse, those bits are ignored; after 32 further idle cycles the next packet is delivered.
5. Async reset asserted mid-SHIFT (bit 30) while a packet is pending -> all outputs 0 immediately, pending cleared, the next full packet is delivered normally.
6. SB_RX_PARITY_CHK_EN defined, packet with bit 62 flipped -> o_parity_err pulse, no o_deser_done. Macro undefined, same packet -> delivered unchanged, o_parity_err=0.

Source files
------------

// File: rtl/sb_rx_deser.sv
// Sideband RX deserializer: assembles LSB-first serial packets, presents them through a
// done/sampled handshake with one pending slot. Optional parity check: SB_RX_PARITY_CHK_EN.
module sb_rx_deser #(
  parameter int unsigned PKT_W  = 64,
  parameter int unsigned GAP_UI = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ser_data,
  input  logic             i_ser_valid,
  input  logic             i_deser_done_sampled,
  output logic [PKT_W-1:0] o_deser_data,
  output logic             o_deser_done,
  output logic             o_overflow,
  output logic             o_frame_err,
  output logic             o_parity_err
);

  localparam int unsigned IdxW = $clog2(PKT_W);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q, state_d;
  logic [6:0]       bit_cnt_q, bit_cnt_d;
  logic [5:0]       gap_cnt_q, gap_cnt_d;
  logic [PKT_W-1:0] shift_q, shift_d;
  logic [PKT_W-1:0] pend_q, pend_d;
  logic [PKT_W-1:0] data_q, data_d;
  logic             pend_vld_q, pend_vld_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;
  logic             complete, pkt_ok, load_pend, pend_free;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shift_d   = shift_q;
    ferr_d    = 1'b0;
    complete  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_ser_valid) begin
          shift_d    = '0;
          shift_d[0] = i_ser_data;
          bit_cnt_d  = 7'd1;
          state_d    = StShift;
        end
      end
      StShift: begin
        if (i_ser_valid) begin
          shift_d[bit_cnt_q[IdxW-1:0]] = i_ser_data;
          bit_cnt_d = (bit_cnt_q == '1) ? bit_cnt_q : bit_cnt_q + 7'd1;
          if (bit_cnt_q == 7'(PKT_W - 1)) begin
            complete  = 1'b1;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = StGap;
          end
        end else begin
          // Truncated packet: this idle cycle already counts toward the gap.
          ferr_d    = 1'b1;
          shift_d   = '0;
          bit_cnt_d = '0;
          gap_cnt_d = 6'd1;
          state_d   = StGap;
        end
      end
      StGap: begin
        if (i_ser_valid) begin
          ferr_d    = 1'b1;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + 6'd1;
          if (gap_cnt_d >= 6'(GAP_UI)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef SB_RX_PARITY_CHK_EN
  logic perr_q, perr_d;

  // Even parity over everything below the top bit, control-parity bit included.
  assign pkt_ok       = ~(^shift_d[PKT_W-2:0]);
  assign perr_d       = complete & ~pkt_ok;
  assign o_parity_err = perr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end
`else
  assign pkt_ok       = 1'b1;
  assign o_parity_err = 1'b0;
`endif

  // A pending packet can only move out while done is low, which forces a low cycle.
  assign load_pend = ~done_q & pend_vld_q;
  assign pend_free = ~pend_vld_q | load_pend;

  always_comb begin
    data_d     = data_q;
    done_d     = done_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d      = 1'b0;
    if (done_q && i_deser_done_sampled) begin
      done_d = 1'b0;
    end
    if (load_pend) begin
      data_d     = pend_q;
      done_d     = 1'b1;
      pend_vld_d = 1'b0;
    end
    if (complete && pkt_ok) begin
      if (!done_q && !pend_vld_q) begin
        data_d = shift_d;
        done_d = 1'b1;
      end else if (pend_free) begin
        pend_d     = shift_d;
        pend_vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      shift_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
    end
  end

  assign o_deser_data = data_q;
  assign o_deser_done = done_q;
  assign o_overflow   = ovf_q;
  assign o_frame_err  = ferr_q;

endmodule
